cam_pixel_capture: RTL

Capture front end for the OV7670 camera. It converts the camera's byte stream (HREF/VSYNC framing, two RGB565 bytes per pixel) into RGB332 pixels with frame-buffer coordinates and a write strobe. The outputs drive the write port of the dual-port M9K frame buffer directly. The block runs in the camera pixel-clock domain, which is the same clock that writes the RAM.

---
 rtl/cam_pixel_capture.sv | 112 +++++++++++
 1 files changed

// File: rtl/cam_pixel_capture.sv
// OV7670 capture front end: RGB565 byte pairs from HREF/VSYNC framing to RGB332
// pixels with frame-buffer coordinates and a single-cycle write strobe.
module cam_pixel_capture #(
    parameter int WIDTH  = 176,
    parameter int HEIGHT = 144
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        VSYNC,
    input  logic        HREF,
    input  logic [7:0]  DATA,
    output logic [7:0]  PIXEL_OUT,
    output logic [14:0] X_ADDR,
    output logic [14:0] Y_ADDR,
    output logic [14:0] W_ADDR,
    output logic        W_EN,
    output logic        FRAME_DONE
);

    localparam logic [14:0] W15    = 15'(WIDTH);
    localparam logic [14:0] H15    = 15'(HEIGHT);
    localparam logic [14:0] H_LAST = 15'(HEIGHT - 1);

    typedef enum logic [1:0] {
        SYNC_WAIT,
        VBLANK,
        CAPTURE
    } state_t;

    state_t      state, state_next;
    logic [14:0] x, y, row_base;
    logic        phase, href_d;
    logic [5:0]  hi_bits;
    logic        pixel_fire, line_end, frame_end, in_window;

    always_ff @(posedge CLK) begin
        if (!RESET_N) state <= SYNC_WAIT;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        pixel_fire = 1'b0;
        line_end   = 1'b0;
        frame_end  = 1'b0;
        case (state)
            SYNC_WAIT: if (VSYNC)  state_next = VBLANK;
            VBLANK:    if (!VSYNC) state_next = CAPTURE;
            CAPTURE: begin
                // VSYNC wins over a coincident phase-1 byte: that pixel is dropped.
                if (VSYNC) begin
                    frame_end  = 1'b1;
                    state_next = VBLANK;
                end else if (HREF) begin
                    pixel_fire = phase;
                end else begin
                    line_end = href_d;
                end
            end
            default: state_next = SYNC_WAIT;
        endcase
        in_window = (x < W15) && (y < H15);
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            PIXEL_OUT  <= '0;
            X_ADDR     <= '0;
            Y_ADDR     <= '0;
            W_ADDR     <= '0;
            W_EN       <= 1'b0;
            FRAME_DONE <= 1'b0;
            x          <= '0;
            y          <= '0;
            row_base   <= '0;
            phase      <= 1'b0;
            href_d     <= 1'b0;
            hi_bits    <= '0;
        end else begin
            W_EN       <= 1'b0;
            FRAME_DONE <= frame_end;
            href_d     <= (state == CAPTURE) && HREF;
            if (state != CAPTURE) begin
                x        <= '0;
                y        <= '0;
                row_base <= '0;
                phase    <= 1'b0;
            end else begin
                if (HREF && !VSYNC) begin
                    phase <= ~phase;
                    if (!phase) hi_bits <= {DATA[7:5], DATA[2:0]};
                end
                if (pixel_fire && in_window) begin
                    PIXEL_OUT <= {hi_bits, DATA[4:3]};
                    X_ADDR    <= x;
                    Y_ADDR    <= y;
                    W_ADDR    <= row_base + x;
                    W_EN      <= 1'b1;
                    x         <= x + 15'd1;
                end
                // Row base stops at the last line so it never passes WIDTH*(HEIGHT-1).
                if (line_end) begin
                    x     <= '0;
                    phase <= 1'b0;
                    if (y < H15)    y        <= y + 15'd1;
                    if (y < H_LAST) row_base <= row_base + W15;
                end
            end
        end
    end

endmodule
